// File: rtl/sobel_frame_capture.sv
// rtl/sobel_frame_capture.sv - sobel stream frame capture buffer with ready/valid raster readout
//
// Purpose:
//   Captures one WIDTH_P x HEIGHT_P frame from the valid-only sobel pixel
//   stream into an internal frame buffer. Once the frame is complete it is
//   replayed in raster order over a ready/valid handshake toward the host
//   transmitter.
//
// Ports:
//   clk_i         clock
//   reset_n_i     synchronous active-low reset
//   valid_i       input pixel valid (no back-pressure)
//   pixel_i       input pixel
//   valid_o       readout pixel valid
//   pixel_o       readout pixel
//   last_o        high with the final pixel of the frame
//   ready_i       downstream ready
//   frame_done_o  one-cycle pulse after the final pixel is captured
//   overflow_o    sticky: a pixel arrived while not capturing
//   busy_o        high while the frame is being read out
//   checksum_o    (SOBEL_FRAME_CAPTURE_CHECKSUM_EN only) mod-2^16 sum of
//                 the last captured frame, updated with frame_done_o
//
// Optional feature macro: SOBEL_FRAME_CAPTURE_CHECKSUM_EN

module ram_1r1w_sync #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH_P)-1:0] waddr_i,
  input  logic [WIDTH_P-1:0]         wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH_P)-1:0] raddr_i,
  output logic [WIDTH_P-1:0]         rdata_o
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

module sobel_frame_capture #(
  parameter int WIDTH_P  = 10,
  parameter int HEIGHT_P = 10
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        valid_i,
  input  logic [7:0]  pixel_i,
  output logic        valid_o,
  output logic [7:0]  pixel_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        frame_done_o,
  output logic        overflow_o,
  output logic        busy_o
`ifdef SOBEL_FRAME_CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0] checksum_o
`endif
);

  localparam int              DEPTH_LP     = WIDTH_P * HEIGHT_P;
  localparam int              AW_LP        = $clog2(DEPTH_LP);
  localparam logic [AW_LP-1:0] LAST_ADDR_LP = AW_LP'(DEPTH_LP - 1);
  localparam logic [AW_LP:0]   DEPTH_CNT_LP = (AW_LP + 1)'(DEPTH_LP);

  typedef enum logic {
    CAPTURE_S = 1'b0,
    READOUT_S = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AW_LP-1:0] wr_addr_q;
  // Read-issue counter is one bit wider so "all issued" is representable
  // even when the frame size is a power of two.
  logic [AW_LP:0]   rd_cnt_q;
  logic [AW_LP-1:0] out_addr_q;
  logic             rd_valid_q;
  logic [7:0]       skid0_q, skid1_q;
  logic [1:0]       skid_cnt_q;
  logic             frame_done_q;
  logic             overflow_q;

  logic       capture_beat;
  logic       last_beat;
  logic       drop_beat;
  logic       transfer;
  logic       last_xfer;
  logic       issue;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata;
  logic       skid_push;
  logic       skid_pop;

  ram_1r1w_sync #(
    .WIDTH_P (8),
    .DEPTH_P (DEPTH_LP)
  ) u_frame_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (pixel_i),
    .re_i    (ram_re),
    .raddr_i (rd_cnt_q[AW_LP-1:0]),
    .rdata_o (ram_rdata)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= CAPTURE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE_S: if (last_beat) state_d = READOUT_S;
      READOUT_S: if (last_xfer) state_d = CAPTURE_S;
      default:   state_d = CAPTURE_S;
    endcase
  end

  // Output / control logic
  always_comb begin
    capture_beat = (state_q == CAPTURE_S) && valid_i;
    last_beat    = capture_beat && (wr_addr_q == LAST_ADDR_LP);
    drop_beat    = (state_q == READOUT_S) && valid_i;
    busy_o       = (state_q == READOUT_S);
    // The RAM word landing this cycle is presented directly when the skid
    // is empty, so the first pixel appears two cycles after the last beat.
    valid_o      = (state_q == READOUT_S) && ((skid_cnt_q != 2'd0) || rd_valid_q);
    if (skid_cnt_q != 2'd0) begin
      pixel_o = skid0_q;
    end else if (rd_valid_q) begin
      pixel_o = ram_rdata;
    end else begin
      pixel_o = 8'd0;
    end
    last_o       = valid_o && (out_addr_q == LAST_ADDR_LP);
    transfer     = valid_o && ready_i;
    last_xfer    = transfer && last_o;
    // A read is only issued when the skid can absorb it plus anything
    // already in flight, even if downstream stalls from now on.
    issue        = (state_q == READOUT_S) && (rd_cnt_q < DEPTH_CNT_LP) &&
                   (({1'b0, skid_cnt_q} + {2'b00, rd_valid_q}) <= 3'd1);
    ram_we       = capture_beat;
    ram_re       = issue;
    // RAM data is consumed straight through when the skid is empty and
    // downstream takes it; otherwise it is parked in the skid.
    skid_push    = rd_valid_q && !((skid_cnt_q == 2'd0) && transfer);
    skid_pop     = transfer && (skid_cnt_q != 2'd0);
    frame_done_o = frame_done_q;
    overflow_o   = overflow_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_addr_q    <= '0;
      rd_cnt_q     <= '0;
      out_addr_q   <= '0;
      rd_valid_q   <= 1'b0;
      skid0_q      <= 8'd0;
      skid1_q      <= 8'd0;
      skid_cnt_q   <= 2'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= last_beat;
      if (drop_beat) begin
        overflow_q <= 1'b1;
      end
      if (capture_beat) begin
        wr_addr_q <= last_beat ? '0 : wr_addr_q + AW_LP'(1);
      end
      if (issue) begin
        rd_cnt_q <= rd_cnt_q + (AW_LP + 1)'(1);
      end
      rd_valid_q <= issue;
      if (transfer) begin
        out_addr_q <= out_addr_q + AW_LP'(1);
      end
      case ({skid_push, skid_pop})
        2'b10: begin
          if (skid_cnt_q == 2'd0) begin
            skid0_q <= ram_rdata;
          end else begin
            skid1_q <= ram_rdata;
          end
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          skid0_q    <= skid1_q;
          skid_cnt_q <= skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd1) begin
            skid0_q <= ram_rdata;
          end else begin
            skid0_q <= skid1_q;
            skid1_q <= ram_rdata;
          end
        end
        default: ;
      endcase
      // Frame fully delivered: rewind the readout side for the next frame.
      if (last_xfer) begin
        rd_cnt_q   <= '0;
        out_addr_q <= '0;
        rd_valid_q <= 1'b0;
        skid_cnt_q <= 2'd0;
      end
    end
  end

`ifdef SOBEL_FRAME_CAPTURE_CHECKSUM_EN
  logic [15:0] csum_acc_q;
  logic [15:0] csum_q;
  logic [15:0] csum_next;

  // First beat of a capture restarts the sum.
  always_comb begin
    csum_next = ((wr_addr_q == '0) ? 16'd0 : csum_acc_q) + {8'd0, pixel_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      csum_acc_q <= 16'd0;
      csum_q     <= 16'd0;
    end else begin
      if (capture_beat) begin
        csum_acc_q <= csum_next;
      end
      if (last_beat) begin
        csum_q <= csum_next;
      end
    end
  end

  assign checksum_o = csum_q;
`endif

endmodule
